// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the arithmetic-unit cluster.
package calc_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int W_DEF   = 16;
  localparam int CL_CBRT = 0;
  localparam int CL_MUL  = 1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; search starts just after last.
module rr_pick import calc_pkg::*; #(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  // Walk from farthest to nearest so the closest requester after last wins.
  always_comb begin
    grant_idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) grant_idx = IW'((int'(last) + k) % N);
  end
  assign any = |req;
endmodule

// File: rtl/adder_sched.sv
// adder_sched: grants the shared adder to one unit per job, starts it,
// muxes its operands for the whole job and acks completion or timeout.
module adder_sched import calc_pkg::*; #(
  parameter  int N   = 2,
  parameter  int W   = W_DEF,
  parameter  int TMO = 4,
  localparam int IW  = idx_w(N),
  localparam int TW  = $clog2(TMO + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    err,
  output logic [N-1:0]    unit_start,
  input  logic [N-1:0]    unit_busy,
  input  logic [N*W-1:0]  unit_a,
  input  logic [N*W-1:0]  unit_b,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  output logic [IW-1:0]   owner,
  output logic            owner_vld
);
  state_t         state, state_n;
  logic [IW-1:0]  last, grant_idx;
  logic [TW-1:0]  tcnt;
  logic           abort, any, own_busy;
  logic [N-1:0]   own_oh;

  rr_pick #(.N(N)) u_pick (
    .req       (req),
    .last      (last),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign own_busy = unit_busy[owner];
  assign own_oh   = N'(1) << owner;

  always_comb begin
    state_n = state == IDLE  ? (any ? START : IDLE)
            : state == START ? WAIT
            : state == WAIT  ? (own_busy ? RUN : (tcnt == '0 ? DONE : WAIT))
            : state == RUN   ? (own_busy ? RUN : DONE)
            : IDLE;
  end

  // Busy is checked before the timeout, so a unit answering on the last
  // allowed WAIT cycle still runs normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(N - 1);
      tcnt  <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) owner <= grant_idx;
      if (state == START) tcnt <= TW'(TMO);
      else if (state == WAIT && !own_busy && tcnt != '0) tcnt <= tcnt - TW'(1);
      if (state == WAIT) abort <= !own_busy && tcnt == '0;
      if (state == DONE) last <= owner;
    end
  end

  assign owner_vld  = state != IDLE;
  assign unit_start = state == START ? own_oh : '0;
  assign ack        = state == DONE ? own_oh : '0;
  assign err        = (state == DONE && abort) ? own_oh : '0;
  assign add_a      = owner_vld ? unit_a[owner*W +: W] : '0;
  assign add_b      = owner_vld ? unit_b[owner*W +: W] : '0;
endmodule
